// File: rtl/uc_pkg.sv
// Shared definitions for the multicycle MIPS control unit: state encodings,
// supported opcodes and ALU operation codes.
package uc_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_FUNCT = 2'd1;
    localparam logic [1:0] ALU_SUB   = 2'd2;

    // True for every opcode the control unit knows how to sequence.
    function automatic logic op_supported(input logic [5:0] op);
        return (op == OP_R) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/uc_multiciclo.sv
// Multicycle MIPS control unit: Moore FSM with a registered state and
// combinational next-state / control decode. Memory states optionally stall
// on mem_ready. While rst is high every output, including state, reads 0.
module uc_multiciclo
    import uc_pkg::*;
#(
    parameter int ALUOP_W     = 3,
    parameter int MEM_WAIT_EN = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         Op,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               MemtoReg,
    output logic               RegWrite,
    output logic               RegDst,
    output logic               AluSrcA,
    output logic [1:0]         AluSrcB,
    output logic [1:0]         PCSource,
    output logic [ALUOP_W-1:0] ALUop,
    output logic               illegal_op,
    output logic [3:0]         state
);

    state_t     state_q;
    state_t     state_d;
    logic       mem_done;
    logic [1:0] aluop_code;

    // With waiting disabled every memory access is treated as finishing at once.
    assign mem_done = (MEM_WAIT_EN != 0) ? mem_ready : 1'b1;

    // State register; reset wins from any state, including mid-stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; memory states hold until the access completes.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (mem_done) state_d = S_DECODE;
            S_DECODE: begin
                case (Op)
                    OP_R:         state_d = S_EXEC;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDIEX;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (Op == OP_LW)      state_d = S_MEMRD;
                else if (Op == OP_SW) state_d = S_MEMWR;
                else                  state_d = S_FETCH;
            end
            S_MEMRD:  if (mem_done) state_d = S_MEMWB;
            S_MEMWR:  if (mem_done) state_d = S_FETCH;
            S_MEMWB:  state_d = S_FETCH;
            S_EXEC:   state_d = S_RWB;
            S_RWB:    state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    // Control decode from the current state; everything unlisted stays 0.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        AluSrcA     = 1'b0;
        AluSrcB     = 2'b00;
        PCSource    = 2'b00;
        aluop_code  = ALU_ADD;
        illegal_op  = 1'b0;
        state       = 4'd0;
        if (!rst) begin
            state = state_q;
            case (state_q)
                S_FETCH: begin
                    MemRead = 1'b1;
                    AluSrcB = 2'b01;
                    IRWrite = mem_done;
                    PCWrite = mem_done;
                end
                S_DECODE: begin
                    AluSrcB    = 2'b11;
                    illegal_op = !op_supported(Op);
                end
                S_MEMADR, S_ADDIEX: begin
                    AluSrcA = 1'b1;
                    AluSrcB = 2'b10;
                end
                S_MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                S_MEMWR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                S_MEMWB: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                end
                S_EXEC: begin
                    AluSrcA    = 1'b1;
                    aluop_code = ALU_FUNCT;
                end
                S_RWB: begin
                    RegWrite = 1'b1;
                    RegDst   = 1'b1;
                end
                S_BRANCH: begin
                    AluSrcA     = 1'b1;
                    aluop_code  = ALU_SUB;
                    PCWriteCond = 1'b1;
                    PCSource    = 2'b01;
                end
                S_JUMP: begin
                    PCWrite  = 1'b1;
                    PCSource = 2'b10;
                end
                S_ADDIWB: begin
                    RegWrite = 1'b1;
                end
                default: begin
                    state = state_q;
                end
            endcase
        end
        ALUop = ALUOP_W'(aluop_code);
    end

endmodule
